// File: rtl/streambuf_in.sv
// Ping-pong input stream buffer: fills one bank from a valid/ready stream while the decoder reads the other.
// Optional framing check on in_last/frame_err is enabled by defining STREAMBUF_IN_LASTCHK_EN.
module streambuf_in #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
`ifdef STREAMBUF_IN_LASTCHK_EN
  input  logic                  in_last,
  output logic                  frame_err,
`endif
  output logic                  blk_valid,
  input  logic                  blk_done,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [2][DEPTH];

  logic [1:0]            full, full_nxt;
  logic                  wbank, wbank_nxt;
  logic                  rbank, rbank_nxt;
  logic [ADDR_WIDTH-1:0] waddr, waddr_nxt;
  logic                  accept;
  logic                  blk_last;
  logic                  release_blk;

  assign in_ready    = !rst && !full[wbank];
  assign blk_valid   = full[rbank];
  assign accept      = in_valid && in_ready;
  assign blk_last    = (waddr == LAST_ADDR);
  assign release_blk = blk_done && full[rbank];

  // Completion and release always touch different banks, since the write bank is never full.
  always_comb begin
    full_nxt  = full;
    wbank_nxt = wbank;
    rbank_nxt = rbank;
    waddr_nxt = waddr;
    if (accept) begin
      if (blk_last) begin
        waddr_nxt       = '0;
        full_nxt[wbank] = 1'b1;
        wbank_nxt       = ~wbank;
      end else begin
        waddr_nxt = waddr + 1'b1;
      end
    end
    if (release_blk) begin
      full_nxt[rbank] = 1'b0;
      rbank_nxt       = ~rbank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= '0;
      wbank   <= 1'b0;
      rbank   <= 1'b0;
      waddr   <= '0;
      rd_data <= '0;
    end else begin
      full    <= full_nxt;
      wbank   <= wbank_nxt;
      rbank   <= rbank_nxt;
      waddr   <= waddr_nxt;
      rd_data <= mem[rbank][rd_addr];
    end
  end

  // Storage carries no reset; partial blocks are simply abandoned.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wbank][waddr] <= in_data;
    end
  end

`ifdef STREAMBUF_IN_LASTCHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else if (accept && (in_last != blk_last)) begin
      frame_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_streambuf_in.sv
// Directed bench for streambuf_in: read data is checked through an expected-value queue.
// Define STREAMBUF_IN_LASTCHK_EN to also exercise the framing check.
module tb_streambuf_in;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       blk_valid;
  logic       blk_done;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;
`ifdef STREAMBUF_IN_LASTCHK_EN
  logic       in_last;
  logic       frame_err;
`endif

  int tests    = 0;
  int failures = 0;
  logic [3:0] exp_q [$];

  streambuf_in #(.DATA_WIDTH(4), .ADDR_WIDTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef STREAMBUF_IN_LASTCHK_EN
    .in_last   (in_last),
    .frame_err (frame_err),
`endif
    .blk_valid (blk_valid),
    .blk_done  (blk_done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkRead(input string tag);
    logic [3:0] exp;
    if (exp_q.size() == 0) begin
      tests++;
      failures++;
      $error("[TB] FAIL %s: observed %0h expected <empty scoreboard>", tag, rd_data);
    end else begin
      exp = exp_q.pop_front();
      checkOutput(tag, {4'h0, rd_data}, {4'h0, exp});
    end
  endtask

  task automatic applyStimulus(input logic [3:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
`ifdef STREAMBUF_IN_LASTCHK_EN
    in_last  = last;
`else
    if (last) in_data = d;
`endif
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
`ifdef STREAMBUF_IN_LASTCHK_EN
    in_last  = 1'b0;
`endif
  endtask

  task automatic readWord(input logic [1:0] a, input logic [3:0] exp, input string tag);
    rd_addr = a;
    exp_q.push_back(exp);
    tick();
    checkRead(tag);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 4'h0;
    blk_done = 1'b0;
    rd_addr  = 2'd0;
`ifdef STREAMBUF_IN_LASTCHK_EN
    in_last  = 1'b0;
`endif

    // Reset values
    tick();
    tick();
    checkOutput("rst_in_ready", {7'd0, in_ready}, 8'd0);
    checkOutput("rst_blk_valid", {7'd0, blk_valid}, 8'd0);
    checkOutput("rst_rd_data", {4'h0, rd_data}, 8'd0);
    rst = 1'b0;
    tick();
    checkOutput("post_rst_in_ready", {7'd0, in_ready}, 8'd1);

    // First block 1..4
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(4'(i), i == 4);
      if (i == 3) checkOutput("fill_blk_valid_early", {7'd0, blk_valid}, 8'd0);
    end
    idle();
    checkOutput("fill_blk_valid", {7'd0, blk_valid}, 8'd1);
    for (int a = 0; a < 4; a++) readWord(2'(a), 4'(a + 1), "fill_read");

    // Second block A..D, then E stalls with both banks full
    applyStimulus(4'hA, 1'b0);
    applyStimulus(4'hB, 1'b0);
    applyStimulus(4'hC, 1'b0);
    applyStimulus(4'hD, 1'b1);
    checkOutput("both_full_in_ready", {7'd0, in_ready}, 8'd0);
    in_valid = 1'b1;
    in_data  = 4'hE;
`ifdef STREAMBUF_IN_LASTCHK_EN
    in_last  = 1'b0;
`endif
    tick();
    tick();
    checkOutput("held_in_ready", {7'd0, in_ready}, 8'd0);
    checkOutput("held_blk_valid", {7'd0, blk_valid}, 8'd1);
    readWord(2'd2, 4'h3, "held_read_bank0");

    // Release: the done edge still reads the old bank
    blk_done = 1'b1;
    rd_addr  = 2'd0;
    exp_q.push_back(4'h1);
    tick();
    blk_done = 1'b0;
    checkRead("done_edge_old_bank");
    checkOutput("release_blk_valid", {7'd0, blk_valid}, 8'd1);
    checkOutput("release_in_ready", {7'd0, in_ready}, 8'd1);
    tick();
    idle();
    readWord(2'd0, 4'hA, "bank1_read");
    readWord(2'd1, 4'hB, "bank1_read");
    readWord(2'd2, 4'hC, "bank1_read");
    readWord(2'd3, 4'hD, "bank1_read");
    blk_done = 1'b1;
    tick();
    blk_done = 1'b0;
    checkOutput("second_done_blk_valid", {7'd0, blk_valid}, 8'd0);
    readWord(2'd0, 4'hE, "held_word_landed");
    blk_done = 1'b1;
    tick();
    blk_done = 1'b0;
    checkOutput("ignored_done_blk_valid", {7'd0, blk_valid}, 8'd0);

    // Complete bank 0 (E,6,7,8)
    applyStimulus(4'h6, 1'b0);
    applyStimulus(4'h7, 1'b0);
    applyStimulus(4'h8, 1'b1);
    idle();
    checkOutput("bank0_blk_valid", {7'd0, blk_valid}, 8'd1);
    readWord(2'd1, 4'h6, "bank0_read");
    readWord(2'd0, 4'hE, "bank0_read");

    // Bank 1 completes on the same edge bank 0 is released
    applyStimulus(4'h9, 1'b0);
    applyStimulus(4'hB, 1'b0);
    applyStimulus(4'hC, 1'b0);
    blk_done = 1'b1;
    applyStimulus(4'hD, 1'b1);
    blk_done = 1'b0;
    idle();
    checkOutput("simul_blk_valid", {7'd0, blk_valid}, 8'd1);
    checkOutput("simul_in_ready", {7'd0, in_ready}, 8'd1);
    readWord(2'd0, 4'h9, "simul_read");
    readWord(2'd1, 4'hB, "simul_read");
    readWord(2'd2, 4'hC, "simul_read");
    readWord(2'd3, 4'hD, "simul_read");
`ifdef STREAMBUF_IN_LASTCHK_EN
    checkOutput("frame_err_clean", {7'd0, frame_err}, 8'd0);
`endif

    // Reset in the middle of a block
    applyStimulus(4'h1, 1'b0);
    applyStimulus(4'h2, 1'b0);
    idle();
    rst = 1'b1;
    #1;
    checkOutput("midrst_blk_valid", {7'd0, blk_valid}, 8'd0);
    checkOutput("midrst_in_ready", {7'd0, in_ready}, 8'd0);
    checkOutput("midrst_rd_data", {4'h0, rd_data}, 8'd0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("midrst_release_in_ready", {7'd0, in_ready}, 8'd1);
    applyStimulus(4'h5, 1'b0);
    applyStimulus(4'h6, 1'b0);
    applyStimulus(4'h7, 1'b0);
    checkOutput("midrst_partial_discarded", {7'd0, blk_valid}, 8'd0);
    applyStimulus(4'h8, 1'b1);
    idle();
    checkOutput("midrst_blk_valid_full", {7'd0, blk_valid}, 8'd1);
    for (int a = 0; a < 4; a++) readWord(2'(a), 4'(a + 5), "midrst_read");

`ifdef STREAMBUF_IN_LASTCHK_EN
    checkOutput("frame_err_before", {7'd0, frame_err}, 8'd0);
    applyStimulus(4'h1, 1'b0);
    applyStimulus(4'h2, 1'b0);
    applyStimulus(4'h3, 1'b1);
    idle();
    checkOutput("frame_err_early_last", {7'd0, frame_err}, 8'd1);
    tick();
    tick();
    checkOutput("frame_err_sticky", {7'd0, frame_err}, 8'd1);
    rst = 1'b1;
    #1;
    checkOutput("frame_err_rst", {7'd0, frame_err}, 8'd0);
    tick();
    rst = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
